// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the ALU address path and a word-wide data memory.
// Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-only memory accesses.
// Sub-word stores use read-modify-write. Load data is lane-selected and sign/zero-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned halfword/word
// accesses complete in one cycle with misalign=1 and do not touch memory.
//
// Handshake: the core raises req together with is_store/funct3/addr/store_data. The request
// is taken only while ready=1, which holds in IDLE only. A req seen while busy is dropped and
// is not queued. done pulses for one cycle when the access finishes. load_data and misalign
// are valid from that cycle onward.
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              ready,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic              st_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sd_q;
    logic              trap;

    // Checks whether funct3 is a defined RV32I encoding for the access direction.
    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !st;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Selects the addressed lane and extends it. Undefined load encodings return 0.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  res = {24'd0, shifted[7:0]};
            3'b001:  res = {{16{half[15]}}, half};
            3'b101:  res = {16'd0, half};
            3'b010:  res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Merges the store byte/halfword into the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] old, input logic [31:0] sd);
        logic [31:0] m;
        m = old;
        if (f3 == 3'b000) begin
            m[{lane, 3'b000} +: 8] = sd[7:0];
        end else if (lane[1]) begin
            m[31:16] = sd[15:0];
        end else begin
            m[15:0] = sd[15:0];
        end
        return m;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // A misaligned halfword or word request bypasses memory and completes with misalign set.
    always_comb begin
        trap = 1'b0;
        if (f3_legal(is_store, funct3)) begin
            if (funct3[1:0] == 2'b01) trap = addr[0];
            else if (funct3 == 3'b010) trap = (addr[1:0] != 2'b00);
        end
    end
`else
    // The offending low address bits are ignored, so no access ever traps.
    assign trap = 1'b0;
`endif

    // These outputs are decoded from state or from the latched address only.
    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dbg_state = state;

    // Main access FSM. mem_wdata doubles as the read-modify-write buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            st_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= '0;
            sd_q      <= 32'd0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'd0;
            load_data <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    misalign <= 1'b0;
                    if (req) begin
                        st_q   <= is_store;
                        f3_q   <= funct3;
                        addr_q <= addr;
                        sd_q   <= store_data;
                        if (trap) begin
                            misalign <= 1'b1;
                            state    <= S_DONE;
                        end else if (is_store && !f3_legal(1'b1, funct3)) begin
                            // An undefined store encoding writes nothing.
                            state <= S_DONE;
                        end else if (is_store && funct3 == 3'b010) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= store_data;
                            state     <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (st_q) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= store_merge(f3_q, addr_q[1:0], mem_rdata, sd_q);
                        state     <= S_WR;
                    end else begin
                        load_data <= load_extend(f3_q, addr_q[1:0], mem_rdata);
                        state     <= S_DONE;
                    end
                end
                S_WR: begin
                    mem_we <= 1'b0;
                    state  <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl using a word memory model.
// The driver pushes hand-computed expectations into exp_q. The monitor pops one
// entry on each done pulse and compares the entry against the DUT and the memory.
module tb_lsu_ctrl;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        int          lat;
        int          we_n;
        logic [7:0]  waddr;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        ready, done, misalign, mem_we;
    logic [31:0] load_data, mem_wdata, mem_rdata, mem_addr;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:63];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          we_cnt = 0;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .ready(ready), .done(done),
        .load_data(load_data), .misalign(misalign), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // memory model: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] = mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) we_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.lat >= 0) chk("latency", cyc - issue_cyc, e.lat);
                    chk("load_data", load_data, e.ld);
                    chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    chk("we_pulses", we_cnt, e.we_n);
                    chk("mem_word", mem[e.waddr[7:2]], e.word);
                end
                we_cnt = 0;
            end
        end
    end

    // driver: one access, then a bounded wait for done
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic hold, input exp_t e);
        int n;
        @(negedge clk);
        n = 0;
        while (!ready && n < 20) begin @(negedge clk); n++; end
        req = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        issue_cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 20);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout addr 0x%08h", a);
        end
        req = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] ld, input logic mis, input int lat,
                                input int we_n, input logic [7:0] waddr, input logic [31:0] word);
        exp_t e;
        e.ld = ld; e.mis = mis; e.lat = lat; e.we_n = we_n; e.waddr = waddr; e.word = word;
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4]  = 32'h8899AABB;  // 0x10
        mem[8]  = 32'h11223344;  // 0x20
        mem[12] = 32'h55667788;  // 0x30

        // reset state
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk); rst = 1'b0;

        // loads: lane select and sign/zero extension
        access(1'b0, 3'b000, 32'h13, 32'd0, 1'b0, mk(32'hFFFFFF88, 1'b0, 2, 0, 8'h10, 32'h8899AABB));
        access(1'b0, 3'b101, 32'h12, 32'd0, 1'b0, mk(32'h00008899, 1'b0, 2, 0, 8'h10, 32'h8899AABB));
        access(1'b0, 3'b001, 32'h10, 32'd0, 1'b0, mk(32'hFFFFAABB, 1'b0, 2, 0, 8'h10, 32'h8899AABB));
        // SB read-modify-write; load_data is held
        access(1'b1, 3'b000, 32'h21, 32'hA5, 1'b0, mk(32'hFFFFAABB, 1'b0, 3, 1, 8'h20, 32'h1122A544));
        // SW with req held high during busy: only one access happens
        access(1'b1, 3'b010, 32'h24, 32'hDEADBEEF, 1'b1, mk(32'hFFFFAABB, 1'b0, 2, 1, 8'h24, 32'hDEADBEEF));
        access(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, mk(32'h1122A544, 1'b0, 2, 0, 8'h20, 32'h1122A544));
        access(1'b0, 3'b100, 32'h22, 32'd0, 1'b0, mk(32'h00000022, 1'b0, 2, 0, 8'h20, 32'h1122A544));
        access(1'b0, 3'b000, 32'h10, 32'd0, 1'b0, mk(32'hFFFFFFBB, 1'b0, 2, 0, 8'h10, 32'h8899AABB));
        // SH to the upper halfword
        access(1'b1, 3'b001, 32'h22, 32'h1234BEEF, 1'b0, mk(32'hFFFFFFBB, 1'b0, 3, 1, 8'h20, 32'hBEEFA544));
        access(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, mk(32'hBEEFA544, 1'b0, 2, 0, 8'h20, 32'hBEEFA544));
        // illegal encodings
        access(1'b0, 3'b011, 32'h10, 32'd0, 1'b0, mk(32'h00000000, 1'b0, 2, 0, 8'h10, 32'h8899AABB));
        access(1'b1, 3'b100, 32'h24, 32'd0, 1'b0, mk(32'h00000000, 1'b0, -1, 0, 8'h24, 32'hDEADBEEF));
        // misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b0, 3'b010, 32'h22, 32'd0, 1'b0, mk(32'h00000000, 1'b1, 1, 0, 8'h20, 32'hBEEFA544));
        access(1'b0, 3'b101, 32'h23, 32'd0, 1'b0, mk(32'h00000000, 1'b1, 1, 0, 8'h20, 32'hBEEFA544));
`else
        access(1'b0, 3'b010, 32'h22, 32'd0, 1'b0, mk(32'hBEEFA544, 1'b0, 2, 0, 8'h20, 32'hBEEFA544));
        access(1'b0, 3'b101, 32'h23, 32'd0, 1'b0, mk(32'h0000BEEF, 1'b0, 2, 0, 8'h20, 32'hBEEFA544));
`endif

        // reset while an SH is in the RD state
        @(negedge clk);
        req = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 32'h30; store_data = 32'h0000CAFE;
        @(posedge clk); #1;
        req = 1'b0;
        chk("sh_in_rd", {30'd0, dbg_state}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        chk("abort_load_data", load_data, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_mem_word", mem[12], 32'h55667788);
        rst = 1'b0;
        we_cnt = 0;
        @(negedge clk);
        chk("abort_ready_after", {31'd0, ready}, 32'd1);

        // post-reset traffic
        access(1'b0, 3'b001, 32'h30, 32'd0, 1'b0, mk(32'h00007788, 1'b0, 2, 0, 8'h30, 32'h55667788));
        access(1'b1, 3'b000, 32'h30, 32'h80, 1'b0, mk(32'h00007788, 1'b0, 3, 1, 8'h30, 32'h55667780));
        access(1'b0, 3'b000, 32'h30, 32'd0, 1'b0, mk(32'hFFFFFF80, 1'b0, 2, 0, 8'h30, 32'h55667780));
        access(1'b0, 3'b000, 32'h31, 32'd0, 1'b0, mk(32'h00000077, 1'b0, 2, 0, 8'h30, 32'h55667780));

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expected %0d", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
